// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus-mapped interval timer: register offsets,
// CTRL bit positions and the interrupt FSM state encoding.
package bus_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_OVR    = 7;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    typedef enum logic [0:0] {
        IRQ_IDLE    = ST_IDLE,
        IRQ_PENDING = ST_PENDING
    } irq_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: counts 0..PRESCALE-1 while enabled and pulses tick
// for one cycle on the last count; held at zero while disabled or cleared.
module timer_prescaler #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int             W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Bus-mapped interval timer with a 4-byte register window and a level
// interrupt held until acknowledged. Define BUS_TIMER_OVERRUN_EN to latch
// an overrun flag in CTRL bit7 when an expiry lands while still pending.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         PRESCALE  = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       INTERRUPT_RAISE,
    input  logic       INTERRUPT_ACK
);

    logic       rst_n;
    logic [7:0] offset;
    logic [1:0] reg_sel;
    logic       in_window, wr_en, rd_en;
    logic       ctrl_wr, period_wr, clear_wr;
    logic       ctrl_en, ctrl_reload, ovr;
    logic [7:0] period, count;
    logic       tick, tick_eff, at_last, expiry;
    irq_state_e irq_state, irq_next;
    logic [7:0] rd_mux, rd_data, rd_out;
    logic       rd_req, rd_oe;

    // Assert asynchronously, release on the first edge after RESET rises.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rst_n <= 1'b0;
        else        rst_n <= 1'b1;
    end

    assign offset    = BUS_ADDR - BASE_ADDR;
    assign reg_sel   = offset[1:0];
    assign in_window = (offset[7:2] == 6'd0);
    assign wr_en     = BUS_WE && in_window;
    assign rd_en     = !BUS_WE && in_window;
    assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL);
    assign period_wr = wr_en && (reg_sel == REG_PERIOD);
    assign clear_wr  = wr_en && (reg_sel == REG_CLEAR);

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (CLK),
        .rst_n  (rst_n),
        .enable (ctrl_en),
        .clear  (clear_wr),
        .tick   (tick)
    );

    assign tick_eff = tick && !clear_wr;
    assign at_last  = (count == period - 8'd1);
    assign expiry   = tick_eff && (period != 8'd0) && at_last;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear_wr) begin
            count <= 8'd0;
        end else if (tick_eff) begin
            count <= ((period == 8'd0) || at_last) ? 8'd0 : count + 8'd1;
        end
    end

    // A CTRL write overrides the one-shot auto-disable in the same cycle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en     <= 1'b0;
            ctrl_reload <= 1'b0;
            period      <= 8'd0;
        end else begin
            if (period_wr) period <= BUS_DATA;
            if (ctrl_wr) begin
                ctrl_en     <= BUS_DATA[CTRL_EN];
                ctrl_reload <= BUS_DATA[CTRL_RELOAD];
            end else if (expiry && !ctrl_reload) begin
                ctrl_en <= 1'b0;
            end
        end
    end

`ifdef BUS_TIMER_OVERRUN_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= 1'b0;
        end else if (expiry && (irq_state == IRQ_PENDING) && !INTERRUPT_ACK) begin
            ovr <= 1'b1;
        end else if (ctrl_wr && BUS_DATA[CTRL_OVR]) begin
            ovr <= 1'b0;
        end
    end
`else
    assign ovr = 1'b0;
`endif

    // NOTE: default assignment first so no latch is inferred.
    always_comb begin
        irq_next = irq_state;
        case (irq_state)
            IRQ_IDLE:    if (expiry) irq_next = IRQ_PENDING;
            IRQ_PENDING: if (INTERRUPT_ACK && !expiry) irq_next = IRQ_IDLE;
            default:     irq_next = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) irq_state <= IRQ_IDLE;
        else        irq_state <= irq_next;
    end

    assign INTERRUPT_RAISE = (irq_state == IRQ_PENDING);

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            REG_CTRL: begin
                rd_mux[CTRL_EN]     = ctrl_en;
                rd_mux[CTRL_RELOAD] = ctrl_reload;
                rd_mux[CTRL_OVR]    = ovr;
            end
            REG_PERIOD: rd_mux = period;
            REG_COUNT:  rd_mux = count;
            default:    rd_mux = 8'h00;
        endcase
    end

    // Read value captured at the address edge, then driven for exactly one
    // full cycle starting at the following edge.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_req  <= 1'b0;
            rd_data <= 8'h00;
            rd_oe   <= 1'b0;
            rd_out  <= 8'h00;
        end else begin
            rd_req <= rd_en;
            if (rd_en) rd_data <= rd_mux;
            rd_oe  <= rd_req;
            if (rd_req) rd_out <= rd_data;
        end
    end

    assign BUS_DATA = rd_oe ? rd_out : 8'hzz;

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BASE_ADDR, default 8'hF0: base of the 4-byte register window (F0..F3).
REQ-002 Parameter PRESCALE, default 100000: CLK cycles per timer tick, minimum 1.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  input  1  reset; asynchronous assert, active-low.
REQ-005 BUS_ADDR  input  8  bus address from the microprocessor.
REQ-006 BUS_DATA  inout  8  shared bus data; driven only during a read response, else high-Z.
REQ-007 BUS_WE  input  1  bus write strobe, active-high.
REQ-008 INTERRUPT_RAISE  output  1  interrupt request; maps to one bit of BUS_INTERRUPTS_RAISE.
REQ-009 INTERRUPT_ACK  input  1  one-cycle acknowledge from the microprocessor.

Function
REQ-010 Register map (offset from BASE_ADDR): 0 CTRL (bit0 EN, bit1 RELOAD, bit7 OVR), 1 PERIOD, 2 COUNT (read-only), 3 CLEAR (write-only, any data).
REQ-011 Write: BUS_WE=1 and address in window at edge N -> register updated at edge N; out-of-window writes ignored.
REQ-012 Read: BUS_WE=0 and address in window at edge N -> BUS_DATA driven with the register value sampled at edge N, from edge N+1 until edge N+2; one-cycle latency, registered output enable.
REQ-013 Reads of CLEAR return 8'h00; writes to COUNT are ignored; writing CTRL bit7=1 clears OVR, bit7=0 leaves it.
REQ-014 Prescaler counts 0..PRESCALE-1 while EN=1, emits a one-cycle tick on wrap; it is held at 0 while EN=0.
REQ-015 On tick: COUNT==PERIOD-1 -> COUNT<=0 and expiry event; otherwise COUNT<=COUNT+1 (8-bit).
REQ-016 PERIOD==0: COUNT holds 0 and no expiry event is generated.
REQ-017 On expiry with RELOAD=0: EN cleared at the same edge (one-shot); with RELOAD=1, EN is unchanged.
REQ-018 CLEAR write: COUNT and the prescaler are zeroed at that edge; a tick in the same cycle is discarded.
REQ-019 Interrupt FSM states: IDLE (RAISE=0) and PENDING (RAISE=1); IDLE->PENDING on expiry; PENDING->IDLE on ACK.
REQ-020 ACK and expiry in the same cycle: FSM stays PENDING and RAISE stays 1.
REQ-021 ACK while IDLE is ignored.
REQ-022 CTRL write and expiry in the same cycle: the written EN/RELOAD values take precedence, and the expiry is still raised.

Reset
REQ-023 RESET=0 asynchronously clears CTRL, PERIOD, COUNT, prescaler and OVR, and puts the FSM in IDLE.
REQ-024 During reset: INTERRUPT_RAISE=0, BUS_DATA high-Z, any read response in flight is cancelled.
REQ-025 Reset deassertion is synchronized internally; the first bus access is accepted on the second edge after release.

Configuration
REQ-026 Macro BUS_TIMER_OVERRUN_EN defined: an expiry while PENDING (with no ACK in that cycle) sets OVR in CTRL bit7.
REQ-027 BUS_TIMER_OVERRUN_EN undefined: CTRL bit7 reads 0, OVR logic is absent, and overlapping expiries merge silently.

Structure
REQ-028 Package bus_timer_pkg holds the register offset constants, CTRL bit indices and the interrupt-FSM state enum.
REQ-029 Sub-module timer_prescaler (inputs: enable, clear; output: tick) holds the prescaler; everything else stays in bus_timer.

Verification
REQ-030 Reset check: RESET=0 mid-PENDING -> RAISE=0 within the same cycle and BUS_DATA=Z; after release, reads of F0/F1/F2 return 00.
REQ-031 Basic expiry: PRESCALE=2; write F1=03 then F0=03 -> RAISE rises 6 cycles after enable; COUNT reads 00,01,02 in between.
REQ-032 Read timing: write F1=5A, then read F1 -> BUS_DATA=5A exactly on the cycle after the read edge and Z before/after; a read at 0x10 leaves BUS_DATA at Z.
REQ-033 One-shot: F0=01, PERIOD=02 -> a single expiry, then F0 reads 00; ACK pulse drops RAISE the next edge.
REQ-034 Overrun: macro defined, RELOAD, no ACK across two expiries -> F0 reads 83; write F0=83 -> OVR cleared, reads 03.
REQ-035 Collision: ACK coincident with a second expiry -> RAISE stays 1; a later ACK -> RAISE 0.
